// File: rtl/vtpg_cfg_ctrl.sv
// rtl/vtpg_cfg_ctrl.sv - shadow/active timing configuration controller for a video test pattern generator
//
// Purpose: holds ten shadow timing registers written over a simple write port,
// validates them on commit and copies them into the active set either at once
// (generator stopped) or at the next vertical sync rise (generator running),
// holding the generator in reset for two cycles around the update.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   1 = generator runs, 0 = generator held in reset
//   cfg_wr/addr/wdata/ready  shadow register write (accepted on cfg_wr & cfg_ready)
//   commit                   request to apply shadow to active
//   vs_in                    vertical sync from generator
//   gen_rst_n                active-low generator reset
//   tHS_START..tV_END        active timing registers
//   pending                  commit waiting for frame boundary or applying
//   cfg_err                  one-cycle error pulse (bad address or invalid commit)
//   frame_cnt                frames started since the generator began running
module vtpg_cfg_ctrl #(
    parameter int H_BITS  = 12,
    parameter int V_BITS  = 12,
    parameter int FC_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfg_wr,
    input  logic [3:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic               cfg_ready,
    input  logic               commit,
    input  logic               vs_in,
    output logic               gen_rst_n,
    output logic [H_BITS-1:0]  tHS_START,
    output logic [H_BITS-1:0]  tHS_END,
    output logic [H_BITS-1:0]  tHACT_START,
    output logic [H_BITS-1:0]  tHACT_END,
    output logic [H_BITS-1:0]  tH_END,
    output logic [V_BITS-1:0]  tVS_START,
    output logic [V_BITS-1:0]  tVS_END,
    output logic [V_BITS-1:0]  tVACT_START,
    output logic [V_BITS-1:0]  tVACT_END,
    output logic [V_BITS-1:0]  tV_END,
    output logic               pending,
    output logic               cfg_err,
    output logic [FC_BITS-1:0] frame_cnt
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;
    localparam logic [1:0] ST_APPLY = 2'd3;

    localparam logic [H_BITS-1:0] H_DEF [5] = '{H_BITS'(10), H_BITS'(20), H_BITS'(40), H_BITS'(50), H_BITS'(60)};
    localparam logic [V_BITS-1:0] V_DEF [5] = '{V_BITS'(11), V_BITS'(21), V_BITS'(25), V_BITS'(35), V_BITS'(40)};

    logic [1:0]         state_q, state_d;
    logic [H_BITS-1:0]  sh_h_q [5], sh_h_d [5], act_h_q [5], act_h_d [5];
    logic [V_BITS-1:0]  sh_v_q [5], sh_v_d [5], act_v_q [5], act_v_d [5];
    logic               err_q, err_d;
    logic               vs_d_q, vs_d_d;
    logic               apply_cnt_q, apply_cnt_d;
    logic [FC_BITS-1:0] fc_q, fc_d;

    logic wr_ok, wr_bad, shadow_ok, commit_eval, vs_rise;

    assign gen_rst_n = (state_q == ST_RUN) || (state_q == ST_PEND);
    assign cfg_ready = (state_q == ST_STOP) || (state_q == ST_RUN);
    assign pending   = (state_q == ST_PEND) || (state_q == ST_APPLY);
    assign cfg_err   = err_q;
    assign frame_cnt = fc_q;
    assign vs_rise   = vs_in & ~vs_d_q;

    assign tHS_START   = act_h_q[0];
    assign tHS_END     = act_h_q[1];
    assign tHACT_START = act_h_q[2];
    assign tHACT_END   = act_h_q[3];
    assign tH_END      = act_h_q[4];
    assign tVS_START   = act_v_q[0];
    assign tVS_END     = act_v_q[1];
    assign tVACT_START = act_v_q[2];
    assign tVACT_END   = act_v_q[3];
    assign tV_END      = act_v_q[4];

    always_comb begin
        wr_ok  = cfg_wr & cfg_ready;
        wr_bad = wr_ok & (cfg_addr >= 4'd10);

        // Shadow next value includes a same-cycle write, so a commit
        // issued alongside a write validates and applies the new data.
        sh_h_d = sh_h_q;
        sh_v_d = sh_v_q;
        if (wr_ok && !wr_bad) begin
            if (cfg_addr < 4'd5) begin
                sh_h_d[cfg_addr[2:0]] = cfg_wdata[H_BITS-1:0];
            end else begin
                sh_v_d[3'(cfg_addr - 4'd5)] = cfg_wdata[V_BITS-1:0];
            end
        end

        shadow_ok = (sh_h_d[0] < sh_h_d[1]) && (sh_h_d[1] <= sh_h_d[4]) &&
                    (sh_h_d[2] < sh_h_d[3]) && (sh_h_d[3] <= sh_h_d[4]) &&
                    (sh_v_d[0] < sh_v_d[1]) && (sh_v_d[1] <= sh_v_d[4]) &&
                    (sh_v_d[2] < sh_v_d[3]) && (sh_v_d[3] <= sh_v_d[4]);

        // A RUN-state commit is dropped when enable falls in the same cycle.
        commit_eval = commit && ((state_q == ST_STOP) || (state_q == ST_RUN && enable));

        state_d     = state_q;
        act_h_d     = act_h_q;
        act_v_d     = act_v_q;
        err_d       = wr_bad;
        apply_cnt_d = apply_cnt_q;
        fc_d        = fc_q;

        case (state_q)
            ST_STOP: begin
                if (commit_eval) begin
                    if (shadow_ok) begin
                        act_h_d = sh_h_d;
                        act_v_d = sh_v_d;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (vs_rise) fc_d = fc_q + 1'b1;
                if (commit_eval) begin
                    if (shadow_ok) state_d = ST_PEND;
                    else           err_d   = 1'b1;
                end
            end
            ST_PEND: begin
                if (vs_rise) begin
                    fc_d = fc_q + 1'b1;
                    if (enable) begin
                        state_d     = ST_APPLY;
                        act_h_d     = sh_h_q;
                        act_v_d     = sh_v_q;
                        apply_cnt_d = 1'b0;
                    end
                end
            end
            default: begin
                // APPLY lasts two cycles: counter 0 then 1.
                if (apply_cnt_q) state_d = ST_RUN;
                else             apply_cnt_d = 1'b1;
            end
        endcase

        if (!enable) state_d = ST_STOP;
        if (state_d == ST_STOP) fc_d = '0;

        vs_d_d = gen_rst_n ? vs_in : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_STOP;
            sh_h_q      <= H_DEF;
            sh_v_q      <= V_DEF;
            act_h_q     <= H_DEF;
            act_v_q     <= V_DEF;
            err_q       <= 1'b0;
            vs_d_q      <= 1'b0;
            apply_cnt_q <= 1'b0;
            fc_q        <= '0;
        end else begin
            state_q     <= state_d;
            sh_h_q      <= sh_h_d;
            sh_v_q      <= sh_v_d;
            act_h_q     <= act_h_d;
            act_v_q     <= act_v_d;
            err_q       <= err_d;
            vs_d_q      <= vs_d_d;
            apply_cnt_q <= apply_cnt_d;
            fc_q        <= fc_d;
        end
    end

endmodule

// File: tb/tb_vtpg_cfg_ctrl.sv
// tb/tb_vtpg_cfg_ctrl.sv - scoreboard testbench for vtpg_cfg_ctrl
module tb_vtpg_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable, cfg_wr, commit, vs_in;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_ready, gen_rst_n, pending, cfg_err;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic [15:0] frame_cnt;

    vtpg_cfg_ctrl #(.H_BITS(12), .V_BITS(12), .FC_BITS(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
        .commit(commit), .vs_in(vs_in), .gen_rst_n(gen_rst_n),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .pending(pending), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Signal ids used by the scoreboard
    localparam int S_GEN = 0, S_RDY = 1, S_PEND = 2, S_ERR = 3, S_FC = 4;
    localparam int S_HS0 = 5, S_HS1 = 6, S_HA0 = 7, S_HA1 = 8, S_HEND = 9;
    localparam int S_VS0 = 10, S_VS1 = 11, S_VA0 = 12, S_VA1 = 13, S_VEND = 14;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int id);
        case (id)
            S_GEN:  return 32'(gen_rst_n);
            S_RDY:  return 32'(cfg_ready);
            S_PEND: return 32'(pending);
            S_ERR:  return 32'(cfg_err);
            S_FC:   return 32'(frame_cnt);
            S_HS0:  return 32'(tHS_START);
            S_HS1:  return 32'(tHS_END);
            S_HA0:  return 32'(tHACT_START);
            S_HA1:  return 32'(tHACT_END);
            S_HEND: return 32'(tH_END);
            S_VS0:  return 32'(tVS_START);
            S_VS1:  return 32'(tVS_END);
            S_VA0:  return 32'(tVACT_START);
            S_VA1:  return 32'(tVACT_END);
            S_VEND: return 32'(tV_END);
            default: return 32'hdead_beef;
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            S_GEN:  return "gen_rst_n";
            S_RDY:  return "cfg_ready";
            S_PEND: return "pending";
            S_ERR:  return "cfg_err";
            S_FC:   return "frame_cnt";
            S_HS0:  return "tHS_START";
            S_HS1:  return "tHS_END";
            S_HA0:  return "tHACT_START";
            S_HA1:  return "tHACT_END";
            S_HEND: return "tH_END";
            S_VS0:  return "tVS_START";
            S_VS1:  return "tVS_END";
            S_VA0:  return "tVACT_START";
            S_VA1:  return "tVACT_END";
            S_VEND: return "tV_END";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: on every falling edge, compare all expectations due by now.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = get_sig(mon_e.sig);
            n_vec++;
            if (mon_act !== mon_e.val) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got %0d expected %0d",
                         sig_name(mon_e.sig), mon_e.cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic chk(input int sig, input int val);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.val = 32'(val);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cfg_wr    = 1'b1;
        cfg_addr  = 4'(a);
        cfg_wdata = 16'(d);
        step();
        cfg_wr    = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic chk_defaults();
        chk(S_GEN, 0); chk(S_RDY, 1); chk(S_PEND, 0); chk(S_ERR, 0); chk(S_FC, 0);
        chk(S_HS0, 10); chk(S_HS1, 20); chk(S_HA0, 40); chk(S_HA1, 50); chk(S_HEND, 60);
        chk(S_VS0, 11); chk(S_VS1, 21); chk(S_VA0, 25); chk(S_VA1, 35); chk(S_VEND, 40);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_wr = 1'b0; commit = 1'b0; vs_in = 1'b0;
        cfg_addr = 4'd0; cfg_wdata = 16'd0;
        step(); step();
        chk_defaults();
        rst = 1'b0;

        // STOP: immediate commit
        wr(4, 80);    chk(S_HEND, 60); chk(S_GEN, 0);
        do_commit();  chk(S_HEND, 80); chk(S_GEN, 0); chk(S_ERR, 0);

        // invalid commit and bad addresses
        wr(1, 5);     chk(S_ERR, 0);
        do_commit();  chk(S_ERR, 1); chk(S_HS1, 20);
        step();       chk(S_ERR, 0);
        wr(1, 20);
        wr(12, 99);   chk(S_ERR, 1);
        step();       chk(S_ERR, 0);
        wr(10, 99);   chk(S_ERR, 1);

        // RUN and frame counting
        enable = 1'b1;
        step();       chk(S_GEN, 1); chk(S_RDY, 1); chk(S_PEND, 0); chk(S_FC, 0); chk(S_HEND, 80);
        vs_in = 1'b1; step(); chk(S_FC, 1);
        vs_in = 1'b0; step(); chk(S_FC, 1);
        vs_in = 1'b1; step(); chk(S_FC, 2);
        step();               chk(S_FC, 2);
        vs_in = 1'b0; step();

        // RUN commit deferred to vs rise
        wr(9, 50);
        do_commit();  chk(S_PEND, 1); chk(S_RDY, 0); chk(S_GEN, 1); chk(S_VEND, 40);
        wr(0, 99);    chk(S_ERR, 0); chk(S_VEND, 40);
        vs_in = 1'b1; step(); chk(S_VEND, 50); chk(S_GEN, 0); chk(S_PEND, 1); chk(S_FC, 3);
        vs_in = 1'b0; step(); chk(S_GEN, 0); chk(S_RDY, 0); chk(S_FC, 3);
        step();       chk(S_GEN, 1); chk(S_PEND, 0); chk(S_RDY, 1); chk(S_HS0, 10); chk(S_FC, 3);

        // enable drop during PEND discards the commit
        wr(5, 12);
        do_commit();  chk(S_PEND, 1);
        enable = 1'b0;
        step();       chk(S_GEN, 0); chk(S_PEND, 0); chk(S_FC, 0); chk(S_VS0, 11);
        step();       chk(S_VS0, 11);

        // reset during APPLY
        enable = 1'b1;
        step();
        do_commit();  chk(S_PEND, 1);
        vs_in = 1'b1; step(); chk(S_VS0, 12); chk(S_VEND, 50); chk(S_GEN, 0);
        rst = 1'b1; vs_in = 1'b0;
        step();       chk_defaults();
        rst = 1'b0; enable = 1'b0;

        // write and commit in the same cycle, then upper boundary
        cfg_wr = 1'b1; cfg_addr = 4'd2; cfg_wdata = 16'd30; commit = 1'b1;
        step();       chk(S_HA0, 30); chk(S_VEND, 40); chk(S_VS0, 11); chk(S_ERR, 0);
        cfg_addr = 4'd1; cfg_wdata = 16'd60;
        step();       chk(S_HS1, 60); chk(S_ERR, 0);
        cfg_addr = 4'd1; cfg_wdata = 16'd61;
        step();       chk(S_HS1, 60); chk(S_ERR, 1);
        cfg_wr = 1'b0; commit = 1'b0;
        step();       chk(S_ERR, 0);

        step(); step();
        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL scoreboard: got %0d undrained entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vtpg_cfg_ctrl.md
VTPG_CFG_CTRL -- requirements
Module: vtpg_cfg_ctrl

Interface
REQ-001 SHALL have parameters: H_BITS, default 12, horizontal timing width; V_BITS, default 12, vertical timing width; FC_BITS, default 16, frame counter width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = generator runs, 0 = generator held in reset.
- cfg_wr  in  1  shadow register write valid.
- cfg_addr  in  4  shadow register index.
- cfg_wdata  in  16  write data, low bits used.
- cfg_ready  out  1  write accepted when cfg_wr & cfg_ready.
- commit  in  1  single-cycle request to apply shadow to active.
- vs_in  in  1  vertical sync from generator.
- gen_rst_n  out  1  active-low reset to generator.
- tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END  out  H_BITS each  active horizontal timing.
- tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END  out  V_BITS each  active vertical timing.
- pending  out  1  commit waiting for frame boundary or applying.
- cfg_err  out  1  one-cycle error pulse.
- frame_cnt  out  FC_BITS  frames started since run began.

Function
REQ-003 SHALL map shadow registers at cfg_addr 0..9 in the port order of REQ-002 (0 = tHS_START ... 9 = tV_END).
REQ-004 SHALL write cfg_wdata truncated to H_BITS/V_BITS into the addressed shadow register on cfg_wr & cfg_ready.
REQ-005 SHALL ignore a write with cfg_addr >= 10 and pulse cfg_err for 1 cycle on the following cycle.
REQ-006 SHALL implement states STOP, RUN, PEND, APPLY.
REQ-007 SHALL drive gen_rst_n = 0 in STOP and APPLY, and 1 in RUN and PEND.
REQ-008 SHALL drive cfg_ready = 1 in STOP and RUN, and 0 in PEND and APPLY.
REQ-009 SHALL drive pending = 1 in PEND and APPLY only.
REQ-010 SHALL transition STOP->RUN when enable=1.
REQ-011 SHALL transition any state->STOP when enable=0; this has priority over all other transitions and discards any pending commit.
REQ-012 SHALL validate the shadow on commit as all of:
- HS_START < HS_END <= H_END
- HACT_START < HACT_END <= H_END
- VS_START < VS_END <= V_END
- VACT_START < VACT_END <= V_END
REQ-013 SHALL, on an invalid commit, leave state and active registers unchanged and pulse cfg_err on the next cycle.
REQ-014 SHALL, on a valid commit in STOP, copy shadow to active on the next clock edge and remain in STOP.
REQ-015 SHALL, on a valid commit in RUN, transition to PEND.
REQ-016 SHALL ignore commit in PEND and APPLY, with no error.
REQ-017 SHALL, in PEND, detect a vs_in rising edge (vs_in=1 and registered vs_d=0), then transition to APPLY and copy shadow to active on that same edge.
REQ-018 SHALL remain in APPLY exactly 2 cycles, then return to RUN.
REQ-019 SHALL, when cfg_wr and commit occur in the same cycle, perform the write first and validate and commit the updated shadow.
REQ-020 SHALL force vs_d to 0 whenever gen_rst_n=0.
REQ-021 SHALL increment frame_cnt by 1 on each vs_in rising edge while in RUN or PEND, wrapping modulo 2^FC_BITS.
REQ-022 SHALL clear frame_cnt on entry to STOP, and hold frame_cnt through APPLY.
REQ-023 SHALL keep active timing outputs stable except at the update points of REQ-014 and REQ-017.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set:
- state = STOP, gen_rst_n = 0, cfg_ready = 1, pending = 0, cfg_err = 0, frame_cnt = 0, vs_d = 0.
- shadow and active both = 10, 20, 40, 50, 60, 11, 21, 25, 35, 40 (addr 0..9).
REQ-025 SHALL let rst override every input, including mid-PEND and mid-APPLY.

Verification
REQ-026 Reset, then enable=1 -> gen_rst_n=1 one cycle later; outputs equal the defaults of REQ-024; frame_cnt counts vs_in rises.
REQ-027 In STOP, write addr 4 = 80 then commit -> tH_END = 80 on the next cycle; gen_rst_n stays 0.
REQ-028 In RUN, write addr 9 = 50 then commit -> pending=1 and cfg_ready=0; tV_END stays 40 until the vs_in rise, then becomes 50; gen_rst_n=0 for exactly 2 cycles; then RUN.
REQ-029 Write addr 1 = 5 (tHS_END < tHS_START = 10), then commit -> cfg_err pulse, active unchanged; write addr 12 -> cfg_err pulse, no register changes.
REQ-030 enable=0 during PEND -> STOP next cycle, frame_cnt=0, active unchanged; rst asserted during APPLY -> all defaults of REQ-024.
